// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply/divide responder for the MIPS multicycle
// datapath. A one-cycle start pulse in IDLE launches a WIDTH-cycle shift-add
// multiply or restoring divide on operand magnitudes. A one-cycle FIX step
// then applies the signs and loads hi/lo. A one-cycle done pulse follows.
// Divide by zero skips the arithmetic entirely and leaves hi/lo untouched.
//
// Ports:
//   clk      - system clock, all state changes on posedge
//   reset    - synchronous active-low reset (0 = reset)
//   start    - one-cycle request, sampled only in IDLE
//   op       - 0 = MULT, 1 = DIV (sampled with start)
//   a, b     - signed operands (rs, rt)
//   busy     - high from the cycle after acceptance until done drops
//   done     - one-cycle completion pulse
//   div_zero - valid with done; DIV with b = 0
//   hi, lo   - MULT: product halves; DIV: remainder / quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MULT = 3'd1,
      S_DIV  = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     trial_s;
   logic [2*WIDTH-1:0] prod_s;
   logic               sign_diff_s;

   // Datapath helpers: partial-product add, trial subtract and signed product
   always_comb begin
      add_s       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
      // Upper remainder shifted left with the next dividend bit appended
      trial_s     = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_q};
      sign_diff_s = sign_a_q ^ sign_b_q;
      if (sign_diff_s) begin
         prod_s = -acc_q;
      end else begin
         prod_s = acc_q;
      end
   end

   // Next-state and datapath update for the IDLE/MULT/DIV/FIX/DONE sequence
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      sign_a_d   = sign_a_q;
      sign_b_d   = sign_b_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      acc_d      = acc_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               op_d     = op;
               sign_a_d = a[WIDTH-1];
               sign_b_d = b[WIDTH-1];
               // Magnitude of the most negative value wraps to itself, which
               // read as unsigned is exactly 2^(WIDTH-1)
               mag_a_d  = a[WIDTH-1] ? -a : a;
               mag_b_d  = b[WIDTH-1] ? -b : b;
               cnt_d    = CW'(WIDTH - 1);
               busy_d   = 1'b1;
               if (op && (b == {WIDTH{1'b0}})) begin
                  state_d    = S_DONE;
                  done_d     = 1'b1;
                  div_zero_d = 1'b1;
               end else if (op) begin
                  state_d = S_DIV;
                  acc_d   = {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
               end else begin
                  state_d = S_MULT;
                  acc_d   = {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MULT: begin
            // Multiplier bits are consumed from the low end of acc
            if (acc_q[0]) begin
               acc_d = {add_s, acc_q[WIDTH-1:1]};
            end else begin
               acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            if (cnt_q == {CW{1'b0}}) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            // acc holds {remainder, dividend/quotient}; quotient bits enter at bit 0
            if (!trial_s[WIDTH]) begin
               acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
            if (cnt_q == {CW{1'b0}}) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_FIX: begin
            if (op_q) begin
               lo_d = sign_diff_s ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CW{1'b0}};
         op_q       <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         mag_a_q    <= {WIDTH{1'b0}};
         mag_b_q    <= {WIDTH{1'b0}};
         acc_q      <= {(2*WIDTH){1'b0}};
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         sign_a_q   <= sign_a_d;
         sign_b_q   <= sign_b_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         acc_q      <= acc_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit: the driver pushes the hand-computed
// result and the cycle at which done must appear. A monitor pops one entry
// per done pulse and compares hi, lo, div_zero, busy and timing.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to time done against the start edge
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: each done pulse is matched against the oldest expectation
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("hi", {32'd0, hi}, {32'd0, e.hi});
            chk("lo", {32'd0, lo}, {32'd0, e.lo});
            chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
            chk("busy_at_done", {63'd0, busy}, 64'd1);
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Issue one request; the expected done cycle is relative to the start edge
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      exp_t e;
      @(negedge clk);
      a = ia; b = ib; op = iop; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.hi  = ehi;
      e.lo  = elo;
      e.dz  = edz;
      e.cyc = edz ? cyc : cyc + 33;
      exp_q.push_back(e);
   endtask

   // Bounded wait until the monitor has drained the scoreboard
   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n = n + 1;
      end
      if (exp_q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout: got %0d pending results expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);

      // Signed and extreme multiplies
      issue(32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      wait_drain();
      issue(32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 1'b0);
      wait_drain();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001, 1'b0);
      wait_drain();

      // Signed divides
      issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      wait_drain();
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 1'b0);
      wait_drain();
      issue(32'd100, 32'hFFFFFFF9, 1'b1, 32'h00000002, 32'hFFFFFFF2, 1'b0);
      wait_drain();

      // Divide by zero keeps the preloaded hi/lo
      issue(32'd7, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      wait_drain();
      issue(32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("dz_cleared", {63'd0, div_zero}, 64'd0);
      chk("dz_busy_cleared", {63'd0, busy}, 64'd0);
      wait_drain();

      // Start during a multiply is ignored: 1000 * -2 = -2000
      issue(32'd1000, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFF, 32'hFFFFF830, 1'b0);
      repeat (9) @(negedge clk);
      a = 32'd3; b = 32'd3; op = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();

      // Reset in the middle of a divide aborts it
      issue(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
      repeat (14) @(negedge clk);
      reset = 1'b0;
      void'(exp_q.pop_front());
      repeat (2) @(negedge clk);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hi", {32'd0, hi}, 64'd0);
      chk("abort_lo", {32'd0, lo}, 64'd0);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      issue(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide responder for the MIPS multicycle datapath. The control FSM initiates MULT and DIV by pulsing start and waits for done. It then writes hi/lo into the HI/LO registers via HiLoWrite, using DivOrM/HiLoSrc to select the source. The block also raises div_zero so the control FSM can branch to exception handling.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
start  input  1  one-cycle request from the control FSM; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV; sampled together with start
a  input  WIDTH  operand rs (multiplicand / dividend), signed two's complement
b  input  WIDTH  operand rt (multiplier / divisor), signed two's complement
busy  output  1  high from the cycle after start is accepted until done drops
done  output  1  one-cycle completion pulse
div_zero  output  1  valid while done=1; set when op=DIV and b=0
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; internal accumulators cleared.
- Reset has priority over everything. Asserting it mid-operation aborts the operation, and no done is issued.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE with start=1 at posedge edge E0:
  - Latch the sign of a, the sign of b, |a|, |b| and op.
  - op=DIV and b=0: go to DONE; set div_zero=1; hi/lo keep their previous values.
  - Otherwise go to MULT or DIV; iteration counter = WIDTH-1; busy=1.
- MULT: unsigned shift-add on magnitudes, one bit per cycle, over a 2*WIDTH-bit product register. Runs for WIDTH cycles, then goes to FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle. Runs for WIDTH cycles, then goes to FIX.
- FIX (one cycle): apply signs, then load hi/lo.
  - Product: negated when sign(a) XOR sign(b).
  - Quotient: negated when sign(a) XOR sign(b).
  - Remainder: takes the sign of the dividend.
  - Quotient truncates toward zero.
  - Go to DONE.
- DONE (one cycle): done=1, busy=1; next state IDLE.
  - busy and done both drop at the following edge.
  - div_zero returns to 0 on leaving DONE.
- Latency: with start accepted at E0, done is high during the cycle after edge E0+WIDTH+1. For WIDTH=32 that is the cycle after E0+33; the divide-by-zero case is the cycle after E0.
- hi/lo change only in FIX and are stable from the done cycle until the next FIX. The control FSM samples them while done=1 or any time later.
- start while not in IDLE (busy=1) is ignored; no queuing.
- start is sampled for exactly one edge. Holding start high is treated as a new request on the first posedge spent in IDLE after DONE.
- Operands a, b and op may change freely after E0.
- Arithmetic rules:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as unsigned WIDTH bits.
  - MULT result is the exact 2*WIDTH-bit signed product; no overflow is flagged.
  - DIV of -2^(WIDTH-1) by -1 gives quotient 0x80000000 and remainder 0 (wraps, no exception).
- No overflow output; mult/div never trigger the Overflow exception path.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release → busy=0, done=0, div_zero=0, hi=0, lo=0.
- Signed MULT: a=7, b=0xFFFFFFFD (-3), op=0 → done exactly 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
- Extreme MULT: a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Then a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Signed DIV:
  - a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: preload hi/lo to nonzero via a prior MULT, then a=5, b=0, op=1 → done on the cycle after the start edge; div_zero=1; hi/lo unchanged; div_zero=0 one cycle later.
- Robustness:
  - Pulse start again at cycle 10 of a MULT with different operands → ignored; original result delivered.
  - Assert reset=0 at cycle 15 of a DIV → no done; all outputs 0; a new start after release works normally.
